// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over an imem req/ack handshake and
// hands {instr, PC+4} to decode over valid/ready; resolves branch/jump/jr redirects.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_pc4,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        DISCARD = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   shadow, shadow_nxt;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   target;
    logic              redirect;
    logic              ack;
    logic              if_valid_nxt;
    logic [XLEN-1:0]   if_instr_nxt;
    logic [XLEN-1:0]   if_pc4_nxt;

    assign imem_addr = pc;
    assign pc_inc    = pc + XLEN'(PC_STEP);
    assign redirect  = redirect_valid & (redirect_sel != 2'b00);
    assign ack       = imem_req & imem_ack;

    // Redirect target resolution
    always_comb begin
        target = jr_target;
        case (redirect_sel)
            2'b01:   target = redirect_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
            2'b10:   target = {redirect_pc4[31:28], jump_index, 2'b00};
            default: target = jr_target;
        endcase
    end

    // Request is held through WAIT/DISCARD; in IDLE it waits for room in the output slot
    always_comb begin
        imem_req = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    imem_req = !if_valid | if_ready;
                WAIT:    imem_req = 1'b1;
                DISCARD: imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        shadow_nxt   = shadow;
        if_valid_nxt = if_valid & !if_ready;
        if_instr_nxt = if_instr;
        if_pc4_nxt   = if_pc4;

        case (state)
            IDLE, WAIT: begin
                if (redirect) begin
                    if_valid_nxt = 1'b0;
                    if ((state == WAIT) && !ack) begin
                        // Address must stay put until the outstanding ack; defer the new PC
                        shadow_nxt = target;
                        state_nxt  = DISCARD;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = IDLE;
                    end
                end else if (ack) begin
                    if_instr_nxt = imem_rdata;
                    if_pc4_nxt   = pc_inc;
                    if_valid_nxt = 1'b1;
                    pc_nxt       = pc_inc;
                    state_nxt    = IDLE;
                end else if (imem_req) begin
                    state_nxt = WAIT;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    if_valid_nxt = 1'b0;
                end
                if (ack) begin
                    pc_nxt    = redirect ? target : shadow;
                    state_nxt = IDLE;
                end else if (redirect) begin
                    shadow_nxt = target;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            shadow   <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc4   <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            shadow   <= shadow_nxt;
            if_valid <= if_valid_nxt;
            if_instr <= if_instr_nxt;
            if_pc4   <= if_pc4_nxt;
        end
    end

endmodule
